// File: rtl/nec_ir_decoder_pkg.sv
// Shared NEC IR decode definitions: FSM states, timing windows in 10 us ticks, key codes.
// Windows are inclusive; the key codes are shared with the snake game's direction input.
package nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    REP_MARK
  } nec_state_t;

  localparam int unsigned LEAD_MARK_MIN  = 800;
  localparam int unsigned LEAD_MARK_MAX  = 1000;
  localparam int unsigned LEAD_SPACE_MIN = 400;
  localparam int unsigned LEAD_SPACE_MAX = 500;
  localparam int unsigned REP_SPACE_MIN  = 180;
  localparam int unsigned REP_SPACE_MAX  = 270;
  localparam int unsigned MARK_MIN       = 40;
  localparam int unsigned MARK_MAX       = 75;
  localparam int unsigned ZERO_MIN       = 40;
  localparam int unsigned ZERO_MAX       = 75;
  localparam int unsigned ONE_MIN        = 140;
  localparam int unsigned ONE_MAX        = 200;

  localparam logic [31:0] UP    = 32'h20DF6A95;
  localparam logic [31:0] DOWN  = 32'h20DFEA15;
  localparam logic [31:0] LEFT  = 32'h20DF1AE5;
  localparam logic [31:0] RIGHT = 32'h20DF9A65;

  function automatic logic in_win(input logic [31:0] v, input int unsigned lo,
                                  input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/nec_ir_decoder_tick_gen.sv
// Free-running prescaler emitting a one-clk tick every TICK_DIV clocks.
// Registered tick, no backpressure; TICK_DIV of 1 yields a tick on every clock.
module nec_tick_gen #(
  parameter int TICK_DIV = 500
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: syncs ir_n, times marks/spaces, holds the last valid 32-bit code.
// Outputs pulse 3 clk after the raw ir_n edge ending a frame; no backpressure, pulses are fire-and-forget.
module nec_ir_decoder
  import nec_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_DIV    = CLK_FREQ_HZ / 100_000,
  parameter int CNT_W       = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ir_n,
  output logic [31:0] direction,
  output logic        code_valid,
  output logic        repeat_pulse,
  output logic        frame_err
);

  logic [1:0]       sync_q;
  logic             ir_act;
  logic             act_q;
  logic             rise;
  logic             fall;
  logic             tick;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      cnt_ext;
  nec_state_t       state;
  logic [31:0]      shreg;
  logic [5:0]       bitcnt;
  logic             has_code;

  nec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Synchronizer resets to the idle (high) line level so release never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      act_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ir_n};
      act_q  <= ir_act;
    end
  end

  assign ir_act  = ~sync_q[1];
  assign rise    = ir_act & ~act_q;
  assign fall    = ~ir_act & act_q;
  assign cnt_ext = 32'(cnt);

  // A tick landing on the strobe cycle already belongs to the new interval.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (rise || fall) begin
      cnt <= tick ? CNT_W'(1) : '0;
    end else if (tick && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      shreg        <= '0;
      bitcnt       <= '0;
      has_code     <= 1'b0;
      direction    <= '0;
      code_valid   <= 1'b0;
      repeat_pulse <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      code_valid   <= 1'b0;
      repeat_pulse <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) state <= LEAD_MARK;
        end
        LEAD_MARK: begin
          if (fall) begin
            if (in_win(cnt_ext, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
              state <= LEAD_SPACE;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else if (cnt_ext > LEAD_MARK_MAX) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        LEAD_SPACE: begin
          if (rise) begin
            if (in_win(cnt_ext, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
              state  <= BIT_MARK;
              bitcnt <= '0;
            end else if (in_win(cnt_ext, REP_SPACE_MIN, REP_SPACE_MAX)) begin
              state <= REP_MARK;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else if (cnt_ext > LEAD_SPACE_MAX) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        BIT_MARK: begin
          if (fall) begin
            if (in_win(cnt_ext, MARK_MIN, MARK_MAX)) begin
              state <= BIT_SPACE;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else if (cnt_ext > MARK_MAX) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        BIT_SPACE: begin
          if (rise) begin
            if (in_win(cnt_ext, ZERO_MIN, ZERO_MAX) || in_win(cnt_ext, ONE_MIN, ONE_MAX)) begin
              // First bit received ends up in bit 31.
              shreg  <= {shreg[30:0], in_win(cnt_ext, ONE_MIN, ONE_MAX)};
              bitcnt <= bitcnt + 6'd1;
              state  <= (bitcnt == 6'd31) ? STOP_MARK : BIT_MARK;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else if (cnt_ext > ONE_MAX) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        STOP_MARK: begin
          if (fall) begin
            // Only the command byte pair is checked; extended NEC reuses the address bytes.
            if (in_win(cnt_ext, MARK_MIN, MARK_MAX) && (shreg[15:8] == ~shreg[7:0])) begin
              direction  <= shreg;
              code_valid <= 1'b1;
              has_code   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end else if (cnt_ext > MARK_MAX) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        REP_MARK: begin
          if (fall) begin
            if (in_win(cnt_ext, MARK_MIN, MARK_MAX)) begin
              repeat_pulse <= has_code;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end else if (cnt_ext > MARK_MAX) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
